regfile_alu_pipe: RTL and testbench

Parametrised successor to the 16×16 register bank and ALU datapath. It holds an `NREGS`×`WIDTH` register file with two-operand issue, immediate extension and operand forwarding. Execution is a two-stage pipeline (issue → execute/writeback) with a flag register and iterative multi-cycle shifts behind a valid/ready handshake. The block sits between the instruction decoder (upstream) and the result/flag consumers (branch unit, debug).

---
 rtl/regfile_alu_pipe.sv | 169 ++++++++++++++++
 tb/tb_regfile_alu_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_pipe.sv
`timescale 1ns/1ps
// Register file + ALU with a two-stage issue -> execute/writeback pipeline,
// operand forwarding, a flag register and iterative one-bit-per-cycle shifts.
module regfile_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int IMMW  = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [AW-1:0]    rdest_i,
    input  logic [AW-1:0]    rsrc_i,
    input  logic [IMMW-1:0]  imm_i,
    input  logic             use_imm_i,
    input  logic             imm_signed_i,
    input  logic             wb_en_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       flags_o,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDC = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_CMP  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_LSH  = 4'h8;
    localparam logic [3:0] OP_RSH  = 4'h9;
    localparam logic [3:0] OP_ARSH = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic             ex_valid_q;
    logic [3:0]       ex_op_q;
    logic [AW-1:0]    ex_rdest_q;
    logic             ex_wb_q;
    logic [WIDTH-1:0] ex_a_q;
    logic [WIDTH-1:0] ex_b_q;
    logic [SW-1:0]    ex_cnt_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       flags_q;

    logic             is_shift, ex_done, ex_wr, accept, cin;
    logic             ovf_add, ovf_sub;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res, logic_res, imm_ext, op_a, reg_b, op_b;
    logic [4:0]       alu_flags;
    logic [SW-1:0]    shift_k;

    // Shifts count down from k; the EX cycle where the count reads 1 is the last.
    assign is_shift   = (ex_op_q == OP_LSH) || (ex_op_q == OP_RSH) || (ex_op_q == OP_ARSH);
    assign ex_done    = ex_valid_q && (!is_shift || (ex_cnt_q == SW'(1)));
    assign ex_wr      = ex_done && ex_wb_q && (ex_op_q <= OP_MOV) && (ex_op_q != OP_CMP);
    assign in_ready_o = !reset && (!ex_valid_q || ex_done);
    assign accept     = in_valid_i && in_ready_o;

    assign cin     = (ex_op_q == OP_ADDC) && flags_q[3];
    assign sum     = {1'b0, ex_a_q} + {1'b0, ex_b_q} + {{WIDTH{1'b0}}, cin};
    assign diff    = {1'b0, ex_a_q} - {1'b0, ex_b_q};
    assign ovf_add = (ex_a_q[MSB] == ex_b_q[MSB]) && (sum[MSB] != ex_a_q[MSB]);
    assign ovf_sub = (ex_a_q[MSB] != ex_b_q[MSB]) && (diff[MSB] != ex_a_q[MSB]);

    always_comb begin
        logic_res = '0;
        case (ex_op_q)
            OP_AND:  logic_res = ex_a_q & ex_b_q;
            OP_OR:   logic_res = ex_a_q | ex_b_q;
            OP_XOR:  logic_res = ex_a_q ^ ex_b_q;
            default: logic_res = ~ex_a_q;
        endcase
    end

    // CMP reports A-B on result even though it never writes back.
    always_comb begin
        alu_res   = '0;
        alu_flags = flags_q;
        case (ex_op_q)
            OP_ADD, OP_ADDC: begin
                alu_res   = sum[WIDTH-1:0];
                alu_flags = {sum[WIDTH-1:0] == '0, sum[WIDTH], ovf_add, 2'b00};
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_flags = {diff[WIDTH-1:0] == '0, diff[WIDTH], ovf_sub, 2'b00};
            end
            OP_CMP: begin
                alu_res   = diff[WIDTH-1:0];
                alu_flags = {ex_a_q == ex_b_q, 2'b00, ex_a_q < ex_b_q,
                             $signed(ex_a_q) < $signed(ex_b_q)};
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                alu_res   = logic_res;
                alu_flags = {logic_res == '0, 4'b0000};
            end
            OP_LSH:  alu_res = {ex_a_q[WIDTH-2:0], 1'b0};
            OP_RSH:  alu_res = {1'b0, ex_a_q[WIDTH-1:1]};
            OP_ARSH: alu_res = {ex_a_q[MSB], ex_a_q[WIDTH-1:1]};
            OP_MOV:  alu_res = ex_b_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        imm_ext = {WIDTH{imm_signed_i & imm_i[IMMW-1]}};
        imm_ext[IMMW-1:0] = imm_i;
        op_a = regs_q[rdest_i];
        if (ex_wr && (ex_rdest_q == rdest_i)) op_a = alu_res;
        reg_b = regs_q[rsrc_i];
        if (ex_wr && (ex_rdest_q == rsrc_i)) reg_b = alu_res;
        op_b    = use_imm_i ? imm_ext : reg_b;
        shift_k = op_b[SW-1:0];
        if (shift_k == '0) shift_k = SW'(1);
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            ex_valid_q  <= 1'b0;
            ex_op_q     <= '0;
            ex_rdest_q  <= '0;
            ex_wb_q     <= 1'b0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= ex_done;
            if (ex_done) begin
                result_q <= alu_res;
                flags_q  <= alu_flags;
            end
            if (ex_wr) regs_q[ex_rdest_q] <= alu_res;
            if (accept) begin
                ex_valid_q <= 1'b1;
                ex_op_q    <= op_i;
                ex_rdest_q <= rdest_i;
                ex_wb_q    <= wb_en_i;
                ex_a_q     <= op_a;
                ex_b_q     <= op_b;
                ex_cnt_q   <= shift_k;
            end else if (ex_done) begin
                ex_valid_q <= 1'b0;
            end else if (ex_valid_q && is_shift) begin
                ex_a_q   <= alu_res;
                ex_cnt_q <= ex_cnt_q - SW'(1);
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign flags_o     = flags_q;
    assign dbg_data_o  = regs_q[dbg_addr_i];

endmodule

// File: tb/tb_regfile_alu_pipe.sv
`timescale 1ns/1ps
// Bench for regfile_alu_pipe: directed scenarios plus a random instruction
// stream checked against an instruction-level reference model.
module tb_regfile_alu_pipe;
    logic        Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        reset, in_valid, in_ready, use_imm, imm_signed, wb_en, out_valid;
    logic [3:0]  op, rdest, rsrc, dbg_addr;
    logic [7:0]  imm;
    logic [15:0] result, dbg_data;
    logic [4:0]  flags;

    logic        reset32, in_valid32, in_ready32, use_imm32, imm_signed32, wb_en32, out_valid32;
    logic [3:0]  op32;
    logic [2:0]  rdest32, rsrc32, dbg_addr32;
    logic [7:0]  imm32;
    logic [31:0] result32, dbg_data32;
    logic [4:0]  flags32;

    regfile_alu_pipe u_dut (
        .Clock(Clock), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .rdest_i(rdest), .rsrc_i(rsrc), .imm_i(imm), .use_imm_i(use_imm),
        .imm_signed_i(imm_signed), .wb_en_i(wb_en), .out_valid_o(out_valid),
        .result_o(result), .flags_o(flags), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );

    regfile_alu_pipe #(.WIDTH(32), .NREGS(8), .IMMW(8)) u_dut32 (
        .Clock(Clock), .reset(reset32), .in_valid_i(in_valid32), .in_ready_o(in_ready32),
        .op_i(op32), .rdest_i(rdest32), .rsrc_i(rsrc32), .imm_i(imm32), .use_imm_i(use_imm32),
        .imm_signed_i(imm_signed32), .wb_en_i(wb_en32), .out_valid_o(out_valid32),
        .result_o(result32), .flags_o(flags32), .dbg_addr_i(dbg_addr32), .dbg_data_o(dbg_data32)
    );

    typedef struct {
        int          due;
        logic [15:0] res;
        logic [4:0]  fl;
        bit          wr;
        logic [3:0]  addr;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        q[$];
    logic [15:0] mR [16];   // architectural state in program order (at issue)
    logic [15:0] cR [16];   // state as of the last completed instruction
    logic [4:0]  mfl, cfl;
    logic [15:0] clast;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction semantics with plain integer arithmetic; flags = {Z,C,F,L,N}.
    function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                  input logic [4:0] fin, output logic [15:0] r,
                                  output logic [4:0] fo, output bit wr);
        int ua, ub, sa, sb, s, c, k;
        bit ovf;
        ua = int'(a); ub = int'(b);
        sa = a[15] ? ua - 65536 : ua;
        sb = b[15] ? ub - 65536 : ub;
        k  = ub % 16;
        if (k == 0) k = 1;
        c  = (o == 4'd1) ? int'(fin[3]) : 0;
        fo = fin; wr = 1'b1; r = '0;
        case (o)
            4'd0, 4'd1: begin
                s = ua + ub + c; r = s[15:0];
                ovf = (sa + sb + c > 32767) || (sa + sb + c < -32768);
                fo = {r == 16'd0, s > 65535, ovf, 2'b00};
            end
            4'd2: begin
                s = ua - ub; r = s[15:0];
                ovf = (sa - sb > 32767) || (sa - sb < -32768);
                fo = {r == 16'd0, ua < ub, ovf, 2'b00};
            end
            4'd3: begin
                s = ua - ub; r = s[15:0]; wr = 1'b0;
                fo = {ua == ub, 2'b00, ua < ub, sa < sb};
            end
            4'd4: begin r = a & b; fo = {r == 16'd0, 4'b0000}; end
            4'd5: begin r = a | b; fo = {r == 16'd0, 4'b0000}; end
            4'd6: begin r = a ^ b; fo = {r == 16'd0, 4'b0000}; end
            4'd7: begin r = ~a;    fo = {r == 16'd0, 4'b0000}; end
            4'd8:  r = 16'(ua << k);
            4'd9:  r = 16'(ua >> k);
            4'd10: r = 16'(sa >>> k);
            4'd11: r = b;
            default: begin r = '0; wr = 1'b0; end
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin mR[i] = '0; cR[i] = '0; end
        mfl = '0; cfl = '0; clast = '0;
        q.delete();
    endtask

    task automatic tick();
        bit   exp_ov;
        exp_t e;
        @(posedge Clock); #1; cyc++;
        exp_ov = (q.size() > 0) && (q[0].due == cyc);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            e = q.pop_front();
            clast = e.res; cfl = e.fl;
            if (e.wr) cR[e.addr] = e.res;
        end
        check("result", result, clast);
        check("flags", flags, cfl);
        check("dbg_data", dbg_data, cR[dbg_addr]);
        dbg_addr = 4'($urandom_range(0, 15));
    endtask

    task automatic send(input logic [3:0] o, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [7:0] im, input bit ui, input bit is, input bit wb);
        logic [15:0] a, b, r;
        logic [4:0]  fo;
        bit          wr;
        int          k, lat, guard;
        exp_t        e;
        op = o; rdest = rd; rsrc = rs; imm = im; use_imm = ui; imm_signed = is; wb_en = wb;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready) begin
            guard++;
            if (guard > 40) begin
                check("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        a = mR[rd];
        if (ui) b = 16'((is && im[7]) ? int'(im) - 256 : int'(im));
        else    b = mR[rs];
        model(o, a, b, mfl, r, fo, wr);
        k = int'(b[3:0]);
        if (k == 0) k = 1;
        lat = (o >= 4'd8 && o <= 4'd10) ? k : 1;
        e.due = cyc + 1 + lat; e.res = r; e.fl = fo; e.wr = wr && wb; e.addr = rd;
        q.push_back(e);
        if (e.wr) mR[rd] = r;
        mfl = fo;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 40) begin tick(); guard++; end
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int c0;
        reset = 1'b1; in_valid = 1'b0; op = '0; rdest = '0; rsrc = '0; imm = '0;
        use_imm = 1'b0; imm_signed = 1'b0; wb_en = 1'b0; dbg_addr = '0;
        reset32 = 1'b1; in_valid32 = 1'b0; op32 = '0; rdest32 = '0; rsrc32 = '0; imm32 = '0;
        use_imm32 = 1'b0; imm_signed32 = 1'b0; wb_en32 = 1'b0; dbg_addr32 = '0;
        clear_model();

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        check("in_ready_during_reset", in_ready, 0);
        reset = 1'b0;
        #1;
        check("in_ready_after_reset", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags, 0);
        check("reset_dbg", dbg_data, 0);

        // Back-to-back dependency through forwarding
        send(4'h0, 4'd1, 4'd0, 8'h05, 1, 0, 1);
        c0 = cyc;
        send(4'h0, 4'd1, 4'd0, 8'hFF, 1, 1, 1);
        check("no_stall", cyc, c0 + 1);
        check("fwd_first_result", result, 16'h0005);
        tick();
        check("fwd_second_result", result, 16'h0004);
        dbg_addr = 4'd1; #1;
        check("fwd_dbg_r1", dbg_data, 16'h0004);

        // Signed overflow, then ADDC wrapping to zero
        send(4'hB, 4'd2, 4'd0, 8'hFF, 1, 1, 1);
        send(4'h9, 4'd2, 4'd0, 8'h01, 1, 0, 1);
        send(4'h0, 4'd2, 4'd0, 8'h01, 1, 0, 1);
        drain();
        check("ovf_result", result, 16'h8000);
        check("ovf_flags", flags, 5'b00100);
        send(4'hB, 4'd3, 4'd0, 8'hFF, 1, 1, 1);
        send(4'h1, 4'd3, 4'd0, 8'h01, 1, 0, 1);
        drain();
        check("addc_result", result, 16'h0000);
        check("addc_flags", flags, 5'b11000);

        // CMP never writes back
        send(4'hB, 4'd4, 4'd0, 8'hFE, 1, 1, 1);
        send(4'hB, 4'd5, 4'd0, 8'h02, 1, 0, 1);
        send(4'h3, 4'd4, 4'd5, 8'h00, 0, 0, 1);
        drain();
        check("cmp_flags", flags, 5'b00001);
        dbg_addr = 4'd4; #1;
        check("cmp_r4_kept", dbg_data, 16'hFFFE);

        // Multi-cycle ARSH and the k=0 case
        send(4'hB, 4'd6, 4'd0, 8'h01, 1, 0, 1);
        send(4'h8, 4'd6, 4'd0, 8'h0F, 1, 0, 1);
        drain();
        check("lsh15_result", result, 16'h8000);
        send(4'hA, 4'd6, 4'd0, 8'h03, 1, 0, 1);
        check("arsh_ready_c1", in_ready, 0);
        tick();
        check("arsh_ready_c2", in_ready, 0);
        tick();
        check("arsh_ready_c3", in_ready, 1);
        tick();
        check("arsh_out_valid", out_valid, 1);
        check("arsh_result", result, 16'hF000);
        send(4'hA, 4'd6, 4'd0, 8'h00, 1, 0, 1);
        check("arsh0_ready", in_ready, 1);
        tick();
        check("arsh0_result", result, 16'hF800);

        // Reset during cycle 2 of a 5-bit LSH
        send(4'hB, 4'd7, 4'd0, 8'h03, 1, 0, 1);
        send(4'h8, 4'd7, 4'd0, 8'h05, 1, 0, 1);
        tick();
        reset = 1'b1; #1;
        check("abort_ready_in_reset", in_ready, 0);
        @(posedge Clock); #1;
        reset = 1'b0;
        clear_model();
        dbg_addr = 4'd7; #1;
        check("abort_ready_after", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_r7", dbg_data, 0);
        repeat (6) tick();

        // Random instruction stream against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) tick();
            else send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 7) != 0);
        end
        drain();

        // 32-bit, 8-register build: SUB 0-1 then a NOP
        @(posedge Clock); #1;
        reset32 = 1'b0; #1;
        check("w32_ready", in_ready32, 1);
        op32 = 4'h2; rdest32 = 3'd0; imm32 = 8'h01; use_imm32 = 1'b1; wb_en32 = 1'b1;
        in_valid32 = 1'b1;
        @(posedge Clock); #1;
        op32 = 4'hD;
        @(posedge Clock); #1;
        in_valid32 = 1'b0;
        check("w32_sub_valid", out_valid32, 1);
        check("w32_sub_result", result32, 32'hFFFFFFFF);
        check("w32_sub_flags", flags32, 5'b01000);
        @(posedge Clock); #1;
        check("w32_nop_valid", out_valid32, 1);
        check("w32_nop_result", result32, 0);
        check("w32_nop_flags", flags32, 5'b01000);
        @(posedge Clock); #1;
        check("w32_pulse_end", out_valid32, 0);
        dbg_addr32 = 3'd0; #1;
        check("w32_dbg_r0", dbg_data32, 32'hFFFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
